ttm4_run_control: RTL and testbench
===================================

# ttm4_run_control

Execution controller for the TTM4 CPU emulator core. It sits between the debounced key pulses and the CPU datapath, and issues a one-cycle clock-enable (CPU_CE) per instruction. The register, stack-pointer, ALU and memory blocks advance only when CPU_CE is high. It provides free-run at a programmable rate, single-step, halt, and a single PC breakpoint, plus an executed-instruction counter for the board display.

## Interface
Parameters:
- RATE_WIDTH, 16, width of the RATE input and the internal rate counter.
- CNT_WIDTH, 16, width of INSTR_CNT.

Ports:
- CLK  in  1  system clock, sole clock domain.
- RST  in  1  synchronous, active-high reset.
- RUN_KEY  in  1  one-cycle pulse from the debouncer; toggles run/halt.
- STEP_KEY  in  1  one-cycle pulse; executes one instruction.
- RATE  in  RATE_WIDTH  CLK cycles per instruction in RUN; 0 is treated as 1.
- BRK_EN  in  1  breakpoint enable.
- BRK_ADDR  in  8  breakpoint program address.
- PC  in  8  current CPU program counter.
- CPU_CE  out  1  registered instruction enable; high for exactly one cycle per instruction.
- STATE  out  2  FSM state: HALT=00, RUN=01, STEP=10, BREAK=11.
- BRK_HIT  out  1  high while in BREAK.
- INSTR_CNT  out  CNT_WIDTH  count of CPU_CE pulses; saturates at all-ones.

## Operation
- Reset values: STATE=HALT, CPU_CE=0, BRK_HIT=0, INSTR_CNT=0, rate counter=0, skip flag=0.
- RATE_EFF = (RATE==0) ? 1 : RATE. RATE is sampled live. A RATE change mid-run takes effect at the next compare. If the counter already exceeds the new RATE_EFF-1, it wraps to 0 without issuing CE.
- HALT:
  - RUN_KEY goes to RUN, clearing the rate counter.
  - Otherwise STEP_KEY goes to STEP.
  - If both keys arrive in the same cycle, RUN wins and STEP_KEY is dropped.
- STEP: CPU_CE=1 during this single cycle, then unconditionally HALT. STEP ignores the breakpoint, and keys arriving in STEP are dropped.
- RUN:
  - The rate counter increments each cycle.
  - In the cycle where counter==RATE_EFF-1, the counter wraps to 0 and the block evaluates:
    - If BRK_EN=1, PC==BRK_ADDR and skip=0: go to BREAK, no CE.
    - Else: CPU_CE=1 next cycle and skip cleared.
  - RUN_KEY goes to HALT; the counter is cleared and any pending CE is suppressed.
  - STEP_KEY is ignored.
- BREAK:
  - BRK_HIT=1 and CPU_CE=0.
  - RUN_KEY goes to RUN with skip=1, so the breakpointed instruction executes once without re-triggering.
  - STEP_KEY goes to STEP, which executes the breakpointed instruction.
  - If both keys arrive in the same cycle, RUN wins.
  - BRK_EN deasserting while in BREAK does not exit BREAK.
- INSTR_CNT increments in the same cycle CPU_CE is high. It holds at all-ones and is cleared only by RST.
- PC is stable whenever CPU_CE=0, so sampling PC at the compare cycle is exact.
- RST asserted mid-operation: the next edge forces all reset values, and any CE in flight is not issued.

## Timing
- All outputs are registered. STATE, BRK_HIT and CPU_CE change only on CLK edges.
- Key pulse at cycle n:
  - RUN_KEY from HALT: STATE=RUN at n+1.
  - STEP_KEY from HALT: STATE=STEP and CPU_CE=1 at n+1; STATE=HALT at n+2.
- RUN entered at cycle n+1 (counter=0): first CPU_CE at n+1+RATE_EFF, then one pulse every RATE_EFF cycles.
  - RATE_EFF=1 gives CPU_CE high continuously from n+2.
- Breakpoint: compare at the cycle where counter==RATE_EFF-1, STATE=BREAK the next cycle. No CE is issued for that slot.
- Resume from BREAK via RUN_KEY at cycle m: first CPU_CE at m+1+RATE_EFF, regardless of PC.
- Maximum CPU_CE duty is 1 pulse per cycle in RUN, and 1 pulse per STEP_KEY otherwise.

## Test plan
- Reset with both keys idle -> STATE=00, CPU_CE=0, INSTR_CNT=0 held for 20 cycles; RUN_KEY pulse asserted during RST is ignored.
- From HALT, three STEP_KEY pulses spaced 5 cycles apart -> exactly three single-cycle CPU_CE pulses, each one cycle after its key, and INSTR_CNT=3.
- RATE=4, RUN_KEY at cycle 10 -> CPU_CE at cycles 15, 19, 23, …; RUN_KEY at cycle 21 -> no CE at 23 and STATE=HALT at 22. Repeat with RATE=0 -> CE every cycle from 12.
- RATE=2, BRK_EN=1, BRK_ADDR=0x05, PC model increments on CE from 0x00 -> STATE=BREAK with PC=0x05 and INSTR_CNT=5. RUN_KEY then -> one CE at PC=0x05, and PC advances to 0x06 with no re-break. STEP_KEY at a second hit -> exactly one CE, then HALT.
- RUN_KEY and STEP_KEY in the same cycle from HALT and from BREAK -> RUN in both cases; STEP_KEY in RUN -> ignored with no extra CE.
- INSTR_CNT preloaded near saturation (CNT_WIDTH=4 build), RATE=1 run -> counter stops at 0xF while CPU_CE continues; RST mid-run -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ttm4_run_control.sv
// ttm4_run_control: execution controller that turns debounced key pulses into a
// one-cycle CPU clock-enable per instruction (free-run at RATE, single-step, halt,
// one PC breakpoint) and counts executed instructions.
// Latency: key -> STATE one cycle; RUN entry -> first CPU_CE after RATE_EFF cycles.
// Backpressure: none; keys arriving where they have no meaning are dropped.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   RUN_KEY, STEP_KEY  one-cycle key pulses (run/halt toggle, single step)
//   RATE               cycles per instruction while running (0 behaves as 1)
//   BRK_EN, BRK_ADDR   breakpoint enable and program address
//   PC                 current CPU program counter
//   CPU_CE             registered instruction enable, one cycle per instruction
//   STATE              HALT=00 RUN=01 STEP=10 BREAK=11
//   BRK_HIT            high while in BREAK
//   INSTR_CNT          saturating count of CPU_CE pulses
module ttm4_run_control #(
  parameter int RATE_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RUN_KEY,
  input  logic                  STEP_KEY,
  input  logic [RATE_WIDTH-1:0] RATE,
  input  logic                  BRK_EN,
  input  logic [7:0]            BRK_ADDR,
  input  logic [7:0]            PC,
  output logic                  CPU_CE,
  output logic [1:0]            STATE,
  output logic                  BRK_HIT,
  output logic [CNT_WIDTH-1:0]  INSTR_CNT
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  localparam logic [RATE_WIDTH-1:0] RATE_ONE = {{(RATE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [RATE_WIDTH-1:0] rate_cnt_q, rate_cnt_d;
  logic                  skip_q, skip_d;
  logic                  ce_q, ce_d;
  logic                  brk_hit_q, brk_hit_d;
  logic [CNT_WIDTH-1:0]  instr_cnt_q, instr_cnt_d;
  logic [RATE_WIDTH-1:0] rate_last;

  // Terminal count of the rate counter, i.e. RATE_EFF-1 with RATE=0 folded to 1.
  assign rate_last = (RATE == '0) ? '0 : (RATE - RATE_ONE);

  always_comb begin
    state_d    = state_q;
    rate_cnt_d = rate_cnt_q;
    skip_d     = skip_q;
    ce_d       = 1'b0;

    case (state_q)
      ST_HALT: begin
        // RUN_KEY has priority; a simultaneous STEP_KEY is dropped.
        if (RUN_KEY) begin
          state_d    = ST_RUN;
          rate_cnt_d = '0;
        end else if (STEP_KEY) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end
      end

      ST_STEP: begin
        state_d = ST_HALT;
      end

      ST_RUN: begin
        if (RUN_KEY) begin
          // Halting in a compare cycle must not let that slot's CE escape.
          state_d    = ST_HALT;
          rate_cnt_d = '0;
        end else if (rate_cnt_q >= rate_last) begin
          // A RATE lowered mid-run can leave the counter past its terminal
          // value; it then wraps silently instead of issuing an extra CE.
          rate_cnt_d = '0;
          if (rate_cnt_q == rate_last) begin
            if (BRK_EN && (PC == BRK_ADDR) && !skip_q) begin
              state_d = ST_BREAK;
            end else begin
              ce_d   = 1'b1;
              skip_d = 1'b0;
            end
          end
        end else begin
          rate_cnt_d = rate_cnt_q + RATE_ONE;
        end
      end

      ST_BREAK: begin
        if (RUN_KEY) begin
          // skip lets the breakpointed instruction execute once on resume.
          state_d    = ST_RUN;
          rate_cnt_d = '0;
          skip_d     = 1'b1;
        end else if (STEP_KEY) begin
          state_d = ST_STEP;
          ce_d    = 1'b1;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    brk_hit_d   = (state_d == ST_BREAK);
    instr_cnt_d = instr_cnt_q;
    if (ce_d && (instr_cnt_q != CNT_MAX)) begin
      instr_cnt_d = instr_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_HALT;
      rate_cnt_q  <= '0;
      skip_q      <= 1'b0;
      ce_q        <= 1'b0;
      brk_hit_q   <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rate_cnt_q  <= rate_cnt_d;
      skip_q      <= skip_d;
      ce_q        <= ce_d;
      brk_hit_q   <= brk_hit_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign CPU_CE    = ce_q;
  assign STATE     = state_q;
  assign BRK_HIT   = brk_hit_q;
  assign INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_ttm4_run_control.sv
module tb_ttm4_run_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RUN_KEY;
  logic        STEP_KEY;
  logic [15:0] RATE;
  logic        BRK_EN;
  logic [7:0]  BRK_ADDR;
  logic [7:0]  PC;
  logic        CPU_CE;
  logic [1:0]  STATE;
  logic        BRK_HIT;
  logic [3:0]  INSTR_CNT;

  int n_checks = 0;
  int n_errs   = 0;

  ttm4_run_control #(.RATE_WIDTH(16), .CNT_WIDTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RUN_KEY   (RUN_KEY),
    .STEP_KEY  (STEP_KEY),
    .RATE      (RATE),
    .BRK_EN    (BRK_EN),
    .BRK_ADDR  (BRK_ADDR),
    .PC        (PC),
    .CPU_CE    (CPU_CE),
    .STATE     (STATE),
    .BRK_HIT   (BRK_HIT),
    .INSTR_CNT (INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // CPU program counter model: advances once per executed instruction.
  always @(posedge CLK) begin
    if (RST)         PC <= 8'h00;
    else if (CPU_CE) PC <= PC + 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  // Keys are high for exactly one cycle; returns in the cycle after the key.
  task automatic pulse(input logic run, input logic stp);
    RUN_KEY  = run;
    STEP_KEY = stp;
    next_cycle();
    RUN_KEY  = 1'b0;
    STEP_KEY = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] want, input int limit, input string tag);
    int  n;
    logic seen;
    n    = 0;
    seen = (STATE == want);
    while (!seen && n < limit) begin
      next_cycle();
      n++;
      seen = (STATE == want);
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    logic [15:0] ce_log;
    int          bad;
    int          ce_cnt;

    RST = 1'b1; RUN_KEY = 1'b0; STEP_KEY = 1'b0;
    RATE = 16'd1; BRK_EN = 1'b0; BRK_ADDR = 8'h00;

    // Reset hold for 20 cycles; a RUN_KEY during reset must be ignored.
    next_cycle();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      RUN_KEY = (i == 5);
      if (i > 0 && (STATE != 2'b00 || CPU_CE || INSTR_CNT != 4'd0 || BRK_HIT)) bad++;
      next_cycle();
    end
    RUN_KEY = 1'b0;
    RST = 1'b0;
    check("rst_hold_bad_cycles", bad, 0);
    next_cycle();
    check("rst_state_after", STATE, 2'b00);
    check("rst_ce_after", CPU_CE, 1'b0);

    // Three single steps spaced 5 cycles apart.
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("step%0d_ce", k), CPU_CE, 1'b1);
      check($sformatf("step%0d_state", k), STATE, 2'b10);
      next_cycle();
      check($sformatf("step%0d_halt", k), STATE, 2'b00);
      for (int j = 0; j < 4; j++) begin
        if (CPU_CE) bad++;
        next_cycle();
      end
    end
    check("step_extra_ce", bad, 0);
    check("step_instr_cnt", INSTR_CNT, 4'd3);

    // RATE=4: CE at key+5, +9; halt key at +11 kills +13; STEP_KEY at +7 ignored.
    do_reset();
    RATE = 16'd4;
    pulse(1'b1, 1'b0);
    ce_log = '0;
    for (int off = 1; off < 16; off++) begin
      ce_log[off] = CPU_CE;
      if (off == 8)  check("rate4_step_ignored_state", STATE, 2'b01);
      if (off == 11) check("rate4_run_before_halt", STATE, 2'b01);
      if (off == 12) check("rate4_halt", STATE, 2'b00);
      RUN_KEY  = (off == 11);
      STEP_KEY = (off == 7);
      next_cycle();
    end
    RUN_KEY = 1'b0; STEP_KEY = 1'b0;
    check("rate4_ce_pattern", ce_log, 16'h0220);
    check("rate4_instr_cnt", INSTR_CNT, 4'd2);

    // RATE=0 behaves as 1: CE every cycle from key+2.
    do_reset();
    RATE = 16'd0;
    pulse(1'b1, 1'b0);
    ce_log = '0;
    for (int off = 1; off < 9; off++) begin
      ce_log[off] = CPU_CE;
      next_cycle();
    end
    check("rate0_ce_pattern", ce_log, 16'h01FC);

    // Breakpoint at 0x05 with RATE=2.
    do_reset();
    RATE = 16'd2; BRK_EN = 1'b1; BRK_ADDR = 8'h05;
    pulse(1'b1, 1'b0);
    wait_state(2'b11, 40, "brk1_reached");
    check("brk1_pc", PC, 8'h05);
    check("brk1_instr_cnt", INSTR_CNT, 4'd5);
    check("brk1_hit", BRK_HIT, 1'b1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (CPU_CE || STATE != 2'b11) bad++;
      next_cycle();
    end
    check("brk1_hold", bad, 0);

    // Resume: breakpointed instruction runs once; move breakpoint to 0x08.
    BRK_ADDR = 8'h08;
    pulse(1'b1, 1'b0);
    check("resume_hit_clear", BRK_HIT, 1'b0);
    ce_log = '0;
    for (int off = 1; off < 7; off++) begin
      ce_log[off] = CPU_CE;
      if (off == 4) check("resume_pc6", PC, 8'h06);
      next_cycle();
    end
    check("resume_ce_pattern", ce_log, 16'h0028);

    wait_state(2'b11, 40, "brk2_reached");
    check("brk2_pc", PC, 8'h08);
    pulse(1'b0, 1'b1);
    check("brk2_step_ce", CPU_CE, 1'b1);
    check("brk2_step_state", STATE, 2'b10);
    next_cycle();
    check("brk2_halt", STATE, 2'b00);
    check("brk2_pc_after", PC, 8'h09);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (CPU_CE) bad++;
      next_cycle();
    end
    check("brk2_no_extra_ce", bad, 0);

    // Both keys together from HALT -> RUN.
    do_reset();
    BRK_EN = 1'b0; RATE = 16'd3;
    pulse(1'b1, 1'b1);
    check("both_halt_state", STATE, 2'b01);
    check("both_halt_ce", CPU_CE, 1'b0);

    // Both keys together from BREAK -> RUN, then skipped instruction executes.
    do_reset();
    RATE = 16'd1; BRK_EN = 1'b1; BRK_ADDR = 8'h00;
    pulse(1'b1, 1'b0);
    next_cycle();
    check("both_brk_enter", STATE, 2'b11);
    pulse(1'b1, 1'b1);
    check("both_brk_state", STATE, 2'b01);
    check("both_brk_ce0", CPU_CE, 1'b0);
    next_cycle();
    check("both_brk_resume_ce", CPU_CE, 1'b1);
    BRK_EN = 1'b0;

    // Saturation with the 4-bit counter, then reset mid-run.
    do_reset();
    RATE = 16'd1;
    pulse(1'b1, 1'b0);
    ce_cnt = 0;
    for (int off = 1; off < 21; off++) begin
      if (CPU_CE) ce_cnt++;
      next_cycle();
    end
    check("sat_ce_count", ce_cnt, 19);
    check("sat_instr_cnt", INSTR_CNT, 4'hF);
    check("sat_ce_continues", CPU_CE, 1'b1);
    RST = 1'b1;
    next_cycle();
    check("midrst_state", STATE, 2'b00);
    check("midrst_ce", CPU_CE, 1'b0);
    check("midrst_hit", BRK_HIT, 1'b0);
    check("midrst_cnt", INSTR_CNT, 4'h0);
    RST = 1'b0;
    next_cycle();
    check("midrst_stays_halt", STATE, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
